// File: rtl/clock_gating_ctrl.sv
// Per-domain clock-gate enable sequencer: gates a domain after a programmable
// idle timeout and restores it on request with a fixed settle delay.
module clock_gating_ctrl #(
  parameter int NB_DOMAINS     = 4,
  parameter int IDLE_CNT_WIDTH = 8,
  parameter int WAKE_CYCLES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      test_mode_i,
  input  logic                      cfg_enable_i,
  input  logic [IDLE_CNT_WIDTH-1:0] cfg_idle_thr_i,
  input  logic [NB_DOMAINS-1:0]     busy_i,
  input  logic [NB_DOMAINS-1:0]     wake_req_i,
  output logic [NB_DOMAINS-1:0]     wake_ack_o,
  output logic [NB_DOMAINS-1:0]     clk_en_o,
  output logic [NB_DOMAINS-1:0]     gated_o
);

  // state   | meaning
  // ST_RUN  | clock running, domain busy or requested
  // ST_IDLE | clock running, counting consecutive idle cycles
  // ST_OFF  | clock gated
  // ST_WAKE | clock restored, settling before the domain counts as running
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_IDLE = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } state_e;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  for (genvar gi = 0; gi < NB_DOMAINS; gi++) begin : g_dom
    state_e                    state_q, state_d;
    logic [IDLE_CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]                wake_cnt_q, wake_cnt_d;
    logic                      clk_en_q, clk_en_d;
    logic                      gated_q, gated_d;
    logic                      idle;

    assign idle = cfg_enable_i & ~busy_i[gi] & ~wake_req_i[gi];

    always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      if (test_mode_i) begin
        state_d    = ST_RUN;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (idle) begin
              state_d    = ST_IDLE;
              idle_cnt_d = '0;
            end
          end
          ST_IDLE: begin
            // >= so a threshold lowered below the running count still gates
            if (!idle) begin
              state_d = ST_RUN;
            end else if (idle_cnt_q >= cfg_idle_thr_i) begin
              state_d = ST_OFF;
            end else begin
              idle_cnt_d = idle_cnt_q + IDLE_CNT_WIDTH'(1);
            end
          end
          ST_OFF: begin
            if (wake_req_i[gi] | busy_i[gi] | ~cfg_enable_i) begin
              state_d    = ST_WAKE;
              wake_cnt_d = '0;
            end
          end
          ST_WAKE: begin
            wake_cnt_d = wake_cnt_q + 4'd1;
            if (wake_cnt_q == WAKE_LAST) state_d = ST_RUN;
          end
          default: state_d = ST_RUN;
        endcase
      end
      clk_en_d = (state_d != ST_OFF);
      gated_d  = (state_d == ST_OFF);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= ST_RUN;
        idle_cnt_q <= '0;
        wake_cnt_q <= '0;
        clk_en_q   <= 1'b1;
        gated_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        idle_cnt_q <= idle_cnt_d;
        wake_cnt_q <= wake_cnt_d;
        clk_en_q   <= clk_en_d;
        gated_q    <= gated_d;
      end
    end

    assign clk_en_o[gi]   = clk_en_q | test_mode_i;
    assign gated_o[gi]    = gated_q;
    // held low during reset so a request that rides through reset gets no ack pulse
    assign wake_ack_o[gi] = wake_req_i[gi] & rst_ni &
                            (test_mode_i | (state_q == ST_RUN) | (state_q == ST_IDLE));
  end

endmodule

// File: doc/clock_gating_ctrl.md
Name: clock_gating_ctrl

Overview:
- Sequences the enable inputs of the per-domain clock-gate cells in the cluster.
- Gates a domain's clock after a programmable number of consecutive idle cycles.
- Restores the clock on request, with a fixed settle delay before acknowledging.
- Sits beside the gate cells: each clk_en_o bit drives one gate's enable, and test mode forces every clock on.

Parameters:
- NB_DOMAINS, 4, number of independently gated clock domains.
- IDLE_CNT_WIDTH, 8, width of the idle threshold and the idle counters.
- WAKE_CYCLES, 2, cycles the clock runs after wake before the domain counts as running; legal range 1..15.

Ports:
- clk_i  in  1  free-running (ungated) clock.
- rst_ni  in  1  asynchronous active-low reset.
- test_mode_i  in  1  scan/test: all clocks forced on.
- cfg_enable_i  in  1  global auto-gating enable; 0 holds all domains running.
- cfg_idle_thr_i  in  IDLE_CNT_WIDTH  idle-cycle threshold, read live.
- busy_i  in  NB_DOMAINS  domain has work in progress.
- wake_req_i  in  NB_DOMAINS  requester needs the domain clock; held high until acknowledged.
- wake_ack_o  out  NB_DOMAINS  domain clock running and stable.
- clk_en_o  out  NB_DOMAINS  enable to the gate cell; flop output.
- gated_o  out  NB_DOMAINS  domain is in state OFF.

Behaviour:
- Reset (async, rst_ni=0):
  - every domain in RUN, idle and wake counters 0;
  - clk_en_o all 1, gated_o all 0, wake_ack_o all 0.
- Domains are fully independent. Each has one FSM {RUN, IDLE, OFF, WAKE}, an idle counter (IDLE_CNT_WIDTH bits) and a wake counter (4 bits).
- Let idle = cfg_enable_i & ~busy_i[i] & ~wake_req_i[i].
- RUN:
  - if idle: go to IDLE, idle counter cleared to 0;
  - otherwise stay in RUN.
- IDLE:
  - if ~idle: go to RUN;
  - else if counter >= cfg_idle_thr_i: go to OFF. The >= comparison covers the threshold being lowered mid-count.
  - else increment the counter.
  - The counter never wraps; it is bounded by the compare.
- OFF:
  - if wake_req_i[i] | busy_i[i] | ~cfg_enable_i: go to WAKE, wake counter cleared to 0;
  - otherwise stay in OFF.
- WAKE:
  - increment the wake counter;
  - when the counter reaches WAKE_CYCLES-1, go to RUN;
  - busy_i and cfg_enable_i are ignored; WAKE always completes.
- clk_en_o[i] flop:
  - loaded from the next state each cycle: 0 iff next state is OFF, 1 otherwise;
  - then ORed with test_mode_i at the output. test_mode_i is static during operation.
- gated_o[i] is a flop, set iff the registered state is OFF.
- Gate timing, with a first idle sample in RUN at cycle t:
  - IDLE at t+1;
  - clk_en_o low from t+2+thr, provided idle holds throughout;
  - so thr=0 gates two cycles after the first idle sample.
- Wake timing, with a request sampled in OFF at cycle t:
  - clk_en_o high at t+1, state WAKE;
  - RUN at t+1+WAKE_CYCLES.
- wake_ack_o[i] = wake_req_i[i] & (state is RUN or IDLE) & ~test_mode_i, or wake_req_i[i] when test_mode_i=1.
  - In IDLE, a wake_req forces RUN next cycle, so the ack held through that edge is consistent.
- Simultaneous events:
  - busy and wake_req together act the same as either alone;
  - cfg_enable_i falling in IDLE gives RUN; in OFF it gives WAKE.
- test_mode_i=1: every FSM goes to RUN on the next cycle, counters are cleared, and clk_en_o is 1 immediately.
- Reset mid-operation (OFF or WAKE): immediate RUN with clk_en_o=1; no ack pulse is generated.

Test Plan:
- Reset, then cfg_enable_i=1, thr=3, busy_i=0, wake_req_i=0 from cycle 0:
  - clk_en_o[0] falls at cycle 5 and gated_o[0] rises at cycle 5;
  - every domain behaves the same way.
- Domain 1 in OFF, WAKE_CYCLES=2, wake_req_i[1] raised at cycle t:
  - clk_en_o[1]=1 at t+1;
  - wake_ack_o[1]=1 at t+3;
  - request dropped at t+4, then domain re-gates after thr+2 idle cycles.
- IDLE with counter at 5, thr=10, thr changed to 2 → OFF next cycle.
- busy_i[2] pulsing one cycle in every three, thr=3 → domain 2 never leaves RUN/IDLE; clk_en_o[2] stays 1.
- All domains OFF, test_mode_i raised:
  - clk_en_o=all 1 the same cycle;
  - all FSMs in RUN the next cycle;
  - wake_ack_o mirrors wake_req_i.
- rst_ni asserted while domain 0 is in WAKE, counter 1 → clk_en_o=all 1 and gated_o=0 asynchronously; RUN after release.
